a2d_rr_sched: RTL

- Round-robin conversion scheduler for the shared A2D SPI master. It owns the 16-bit SPI master that talks to the ADC128S.
- Each `nxt` trigger (inertial-interface valid pulse) runs one channel slot, walking through four slots: left load cell, right load cell, steer pot, battery.
- Each slot is two SPI transactions: the address frame, then a read frame. The ADC returns the sample on the read frame.
- Results are held in registers for the balance, steer and auth logic.

---
 rtl/a2d_pkg.sv | 30 +++
 rtl/a2d_rr_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/a2d_pkg.sv
// +----------------------------------------------------------------------+
// | a2d_pkg : shared types and helpers for the A2D round-robin scheduler |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      GAP   = 3'd2,
      READ  = 3'd3,
      STORE = 3'd4
   } a2d_state_t;

   typedef logic [1:0] slot_t;

   localparam slot_t SLOT_LFT   = 2'd0;
   localparam slot_t SLOT_RGHT  = 2'd1;
   localparam slot_t SLOT_STEER = 2'd2;
   localparam slot_t SLOT_BATT  = 2'd3;

   function automatic logic [15:0] mk_cmd(input logic [2:0] chnl);
      return {2'b00, chnl, 11'h000};
   endfunction

endpackage

`default_nettype wire

// File: rtl/a2d_rr_sched.sv
// +----------------------------------------------------------------------+
// | a2d_rr_sched : round-robin ADC128S slot scheduler over a SPI master  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module a2d_rr_sched
   import a2d_pkg::*;
#(
   parameter logic [2:0]  CH_LFT   = 3'd0,
   parameter logic [2:0]  CH_RGHT  = 3'd4,
   parameter logic [2:0]  CH_STEER = 3'd5,
   parameter logic [2:0]  CH_BATT  = 3'd6,
   parameter int unsigned GAP_CYC  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nxt,
   input  logic [3:0]  en_mask,
   output logic        wrt,
   output logic [15:0] cmd,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic [3:0]  smpl_vld,
   output logic        busy,
   output logic        nxt_drop
);

   localparam logic [3:0] GAP_LD = 4'(GAP_CYC);

   a2d_state_t  state, state_nx;
   slot_t       ptr, ptr_nx;
   slot_t       slot, slot_nx;
   slot_t       pick;
   logic        pick_ok;
   logic        pending, pending_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [11:0] hold, hold_nx;
   logic [15:0] cmd_nx;
   logic [11:0] lft_nx, rght_nx, steer_nx, batt_nx;
   logic [3:0]  vld_nx;
   logic        wrt_nx, drop_nx;
   logic        unused_rd_hi;

   // Only the 12-bit conversion result is meaningful; the top nibble is zero fill.
   assign unused_rd_hi = ^rd_data[15:12];

   assign busy = (state != IDLE);

   function automatic logic [2:0] chan_of(input slot_t s);
      case (s)
         SLOT_LFT:   chan_of = CH_LFT;
         SLOT_RGHT:  chan_of = CH_RGHT;
         SLOT_STEER: chan_of = CH_STEER;
         default:    chan_of = CH_BATT;
      endcase
   endfunction

   // Scan downwards so the smallest offset from the pointer wins.
   always_comb begin
      pick_ok = 1'b0;
      pick    = ptr;
      for (int i = 3; i >= 0; i--) begin
         if (en_mask[ptr + slot_t'(i)]) begin
            pick_ok = 1'b1;
            pick    = ptr + slot_t'(i);
         end
      end
   end

   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      slot_nx    = slot;
      pending_nx = pending;
      cnt_nx     = cnt;
      hold_nx    = hold;
      cmd_nx     = cmd;
      lft_nx     = lft_ld;
      rght_nx    = rght_ld;
      steer_nx   = steer_pot;
      batt_nx    = batt;
      vld_nx     = 4'b0000;
      wrt_nx     = 1'b0;
      drop_nx    = 1'b0;

      if (state != IDLE && nxt) begin
         if (pending) drop_nx    = 1'b1;
         else         pending_nx = 1'b1;
      end

      case (state)
         IDLE: begin
            if (nxt || pending) begin
               if (pick_ok) begin
                  slot_nx    = pick;
                  ptr_nx     = pick + 2'd1;
                  cmd_nx     = mk_cmd(chan_of(pick));
                  wrt_nx     = 1'b1;
                  state_nx   = ADDR;
                  // A fresh trigger coinciding with a pending restart stays queued.
                  pending_nx = pending & nxt;
               end else begin
                  pending_nx = 1'b0;
                  drop_nx    = 1'b1;
               end
            end
         end
         ADDR: begin
            if (done) begin
               cnt_nx   = GAP_LD;
               state_nx = GAP;
            end
         end
         GAP: begin
            if (cnt <= 4'd1) begin
               cnt_nx   = 4'd0;
               wrt_nx   = 1'b1;
               state_nx = READ;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         READ: begin
            if (done) begin
               hold_nx  = rd_data[11:0];
               state_nx = STORE;
            end
         end
         STORE: begin
            case (slot)
               SLOT_LFT:   lft_nx   = hold;
               SLOT_RGHT:  rght_nx  = hold;
               SLOT_STEER: steer_nx = hold;
               default:    batt_nx  = hold;
            endcase
            vld_nx[slot] = 1'b1;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= SLOT_LFT;
         slot      <= SLOT_LFT;
         pending   <= 1'b0;
         cnt       <= 4'd0;
         hold      <= 12'h000;
         cmd       <= 16'h0000;
         lft_ld    <= 12'h000;
         rght_ld   <= 12'h000;
         steer_pot <= 12'h000;
         batt      <= 12'h000;
         smpl_vld  <= 4'b0000;
         wrt       <= 1'b0;
         nxt_drop  <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         slot      <= slot_nx;
         pending   <= pending_nx;
         cnt       <= cnt_nx;
         hold      <= hold_nx;
         cmd       <= cmd_nx;
         lft_ld    <= lft_nx;
         rght_ld   <= rght_nx;
         steer_pot <= steer_nx;
         batt      <= batt_nx;
         smpl_vld  <= vld_nx;
         wrt       <= wrt_nx;
         nxt_drop  <= drop_nx;
      end
   end

endmodule

`default_nettype wire
